// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port frame-buffer RAM between VGA scanout (priority) and a posted-write FIFO.
// Define VGA_FB_ARB_VBLANK_WR_EN to drain writes only outside SCAN (tear-free frames).
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int WBUF_DEPTH = 4,
  parameter int FRAME_PIX  = 307200
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          h_de,
  input  logic                          v_de,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(WBUF_DEPTH):0]   wr_level,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          pix_valid,
  output logic [DATA_W-1:0]             pix_data
);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int LW = PW + 1;
  typedef enum logic [1:0] {OFF, SCAN, VBLANK} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] scan_addr, scan_inc;
  logic [ADDR_W-1:0] fa [WBUF_DEPTH];
  logic [DATA_W-1:0] fd [WBUF_DEPTH];
  logic [PW-1:0] rp, wp;
  logic disp_rd, gate, push, pop, rd_d1;
  assign disp_rd  = en & h_de & v_de;
  assign wr_ready = rst_n & (wr_level != LW'(WBUF_DEPTH));
  assign push     = wr_valid & wr_ready;
  assign pop      = !disp_rd & gate & (wr_level != '0);
  assign scan_inc = (scan_addr == ADDR_W'(FRAME_PIX - 1)) ? '0 : scan_addr + 1'b1;
`ifdef VGA_FB_ARB_VBLANK_WR_EN
  assign gate = (state != SCAN);
`else
  assign gate = 1'b1;
`endif
  always_comb nxt = !en ? OFF : v_de ? SCAN : VBLANK;
  always_ff @(posedge clk) begin
    if (push) begin
      fa[wp] <= wr_addr;
      fd[wp] <= wr_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= OFF;
      scan_addr <= '0;
      rp        <= '0;
      wp        <= '0;
      wr_level  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_d1     <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      state     <= nxt;
      scan_addr <= (nxt != SCAN) ? '0 : disp_rd ? scan_inc : scan_addr;
      wp        <= push ? wp + 1'b1 : wp;
      rp        <= pop ? rp + 1'b1 : rp;
      wr_level  <= wr_level + LW'(push) - LW'(pop);
      mem_en    <= disp_rd | pop;
      mem_we    <= pop;
      mem_addr  <= disp_rd ? scan_addr : fa[rp];
      mem_wdata <= fd[rp];
      rd_d1     <= mem_en & !mem_we;
      pix_valid <= rd_d1;
      pix_data  <= rd_d1 ? mem_rdata : pix_data;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized bench with a queue/array reference model of scanout, posted writes and RAM.
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 19, DATA_W = 8, DEPTH = 4, FRAME_PIX = 1200;
  localparam int LW = $clog2(DEPTH) + 1;
  typedef struct packed {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} wr_t;
  logic clk = 0, rst_n = 0, en = 0, h_de = 0, v_de = 0, wr_valid = 0;
  logic wr_ready, mem_en, mem_we, pix_valid;
  logic [ADDR_W-1:0] wr_addr = '0, mem_addr;
  logic [DATA_W-1:0] wr_data = '0, mem_wdata, mem_rdata, pix_data;
  logic [LW-1:0] wr_level;
  logic [DATA_W-1:0] ram  [1<<ADDR_W];
  logic [DATA_W-1:0] mram [1<<ADDR_W];
  int n_cmp = 0, n_bad = 0;
  wr_t fifo[$];
  int pos = 0;
  logic in_scan = 0, p1v = 0, p2v = 0, x_en = 0, x_we = 0, x_pv = 0, x_pdchk = 1;
  logic [DATA_W-1:0] p1d = '0, p2d = '0, x_pd = '0, x_wd = '0;
  logic [ADDR_W-1:0] x_addr = '0;
  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(DEPTH), .FRAME_PIX(FRAME_PIX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .h_de(h_de), .v_de(v_de),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_level(wr_level),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_data(pix_data));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input logic r, input logic e, input logic h, input logic v, input logic wv,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic rd, gate;
    int lvl;
    wr_t w;
    @(negedge clk);
    check("mem_en", 32'(mem_en), 32'(x_en));
    check("mem_we", 32'(mem_we), 32'(x_we));
    if (x_en) check("mem_addr", 32'(mem_addr), 32'(x_addr));
    if (x_we) check("mem_wdata", 32'(mem_wdata), 32'(x_wd));
    check("wr_level", 32'(wr_level), 32'(fifo.size()));
    check("pix_valid", 32'(pix_valid), 32'(x_pv));
    if (x_pdchk) check("pix_data", 32'(pix_data), 32'(x_pd));
    rst_n = r; en = e; h_de = h; v_de = v; wr_valid = wv; wr_addr = a; wr_data = d;
    #1;
    lvl = fifo.size();
    check("wr_ready", 32'(wr_ready), 32'(r && lvl != DEPTH));
    if (!r) begin
      fifo.delete();
      pos = 0; in_scan = 0; p1v = 0; p2v = 0;
      x_en = 0; x_we = 0; x_addr = '0; x_wd = '0; x_pv = 0; x_pdchk = 1; x_pd = '0;
    end else begin
      rd = e & h & v;
`ifdef VGA_FB_ARB_VBLANK_WR_EN
      gate = !in_scan;
`else
      gate = 1'b1;
`endif
      x_pv = p2v; x_pdchk = p2v;
      if (p2v) x_pd = p2d;
      p2v = p1v; p2d = p1d; p1v = 0;
      x_en = 0; x_we = 0;
      if (rd) begin
        x_en = 1; x_addr = ADDR_W'(pos); p1v = 1; p1d = mram[pos];
        pos = (pos + 1) % FRAME_PIX;
      end else begin
        if (!e || !v) pos = 0;
        if (gate && lvl > 0) begin
          w = fifo.pop_front();
          x_en = 1; x_we = 1; x_addr = w.a; x_wd = w.d;
          mram[w.a] = w.d;
        end
      end
      if (wv && lvl != DEPTH) fifo.push_back({a, d});
      in_scan = e & v;
    end
  endtask
  function automatic logic pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction
  task automatic rnd_wr(input logic r, input logic e, input logic h, input logic v, input int p);
    cycle(r, e, h, v, pct(p), ADDR_W'($urandom_range(0, 255)), DATA_W'($urandom));
  endtask
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = DATA_W'(i * 37 + 5);
      mram[i] = DATA_W'(i * 37 + 5);
    end
    repeat (2) @(posedge clk);
    repeat (3) cycle(0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 640; i++) rnd_wr(1, 1, 1, 1, 30);
    repeat (10) rnd_wr(1, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, 1, ADDR_W'(32'h100 + i), DATA_W'(32'hA0 + i));
    repeat (8) cycle(1, 1, 0, 1, 0, '0, '0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 1, 1, ADDR_W'(32'h10 + i), DATA_W'(32'h50 + i));
    repeat (10) cycle(1, 1, 0, 1, 1, ADDR_W'(32'h14), DATA_W'(32'h54));
    repeat (4) rnd_wr(1, 0, 0, 0, 0);
    for (int l = 0; l < 32; l++) begin
      repeat (40) rnd_wr(1, 1, 1, 1, 20);
      repeat (10) rnd_wr(1, 1, 0, 1, 40);
    end
    repeat (20) rnd_wr(1, 1, 0, 0, 50);
    for (int l = 0; l < 3; l++) begin
      repeat (40) rnd_wr(1, 1, 1, 1, 60);
      repeat (10) rnd_wr(1, 1, 0, 1, 20);
    end
    repeat (1300) rnd_wr(1, 1, 1, 1, 10);
    repeat (10) rnd_wr(1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 1, 1, ADDR_W'(32'h20 + i), DATA_W'(32'h70 + i));
    cycle(0, 1, 1, 1, 0, '0, '0);
    repeat (20) rnd_wr(1, 1, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      rnd_wr(!pct(1), pct(95), pct(70), pct(85), 50);
    repeat (10) cycle(1, 0, 0, 0, 0, '0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port pixel frame-buffer RAM between two users: the VGA scanout read stream and a pixel writer (drawing engine or host).
- Scanout has absolute priority during active video. Writes are posted into a small internal FIFO and drained into the RAM on cycles the display does not need.
- Sits between the h_sync/v_sync timing blocks (source of h_de, v_de, en) and the frame-buffer RAM.

Parameters:
- ADDR_W, 19, frame-buffer address width.
- DATA_W, 8, pixel width.
- WBUF_DEPTH, 4, posted-write FIFO depth; must be a power of 2, ≥2.
- FRAME_PIX, 307200, active pixels per frame (640x480); scan address wraps at this value.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- en  in  1  timing generator running (the `done` level feeding the sync blocks)
- h_de  in  1  horizontal active-video enable
- v_de  in  1  vertical active-video enable
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- wr_level  out  $clog2(WBUF_DEPTH)+1  FIFO occupancy
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a mem_en & !mem_we cycle
- pix_valid  out  1  pix_data valid
- pix_data  out  DATA_W  scanout pixel

Interface conventions:
- Reset rst_n, synchronous, active-low; clock clk.

Behaviour:
- Reset values:
  - All registered outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, pix_valid, pix_data.
  - wr_level is 0; FIFO is emptied; scan address is 0; FSM state is OFF.
  - wr_ready is forced 0 while rst_n is low.
  - A reset mid-operation discards posted writes and any in-flight read.
- disp_rd = en & h_de & v_de, evaluated each cycle.
- FSM states OFF, SCAN, VBLANK; transitions are evaluated each cycle:
  - OFF: entered when en=0. No display reads. Goes to SCAN when en=1 & v_de=1, or to VBLANK when en=1 & v_de=0.
  - SCAN: goes to VBLANK on v_de=0 and to OFF on en=0.
  - VBLANK: goes to SCAN on v_de=1 and to OFF on en=0.
  - The scan address clears to 0 on every entry to OFF or VBLANK.
- Arbitration decision (combinational), registered into the mem_* outputs on the next edge:
  - If disp_rd: read at scan_addr. Then scan_addr increments, wrapping FRAME_PIX-1 -> 0.
  - Else if FIFO not empty (and the write gate below is open): pop the FIFO head and write it.
  - Else: mem_en=0.
  - A display read is never delayed or dropped.
- Scanout latency is fixed at 3 cycles:
  - disp_rd at cycle t -> mem_en=1, mem_we=0 at t+1 -> mem_rdata at t+2 -> pix_data/pix_valid registered at t+3.
  - pix_valid=1 only for display reads, never for writes.
  - The sync pipeline upstream of the DAC delays hsync/vsync by 3 to match.
- Write FIFO:
  - wr_ready = rst_n & (wr_level != WBUF_DEPTH); it depends only on the full flag.
  - A push and a pop in the same cycle are both legal; wr_level is unchanged.
  - FIFO order is preserved. Two posted writes to the same address land in acceptance order.
  - A write accepted at cycle t reaches mem_* no earlier than t+2, because the FIFO is registered.
  - No read-after-write bypass: scanout may show the old pixel until the write drains. This is accepted as tearing.
- Write gate: writes drain in any cycle with disp_rd=0. This includes horizontal blanking inside SCAN, VBLANK, and OFF.
- Throughput:
  - Sustained write bandwidth during SCAN equals the horizontal-blank cycles.
  - When the FIFO is full, wr_ready=0 until a blank cycle pops an entry.

Optional Feature:
- Macro VGA_FB_ARB_VBLANK_WR_EN.
- Defined: the write gate is open only in VBLANK and OFF states. Posted writes wait out horizontal blanking inside SCAN, giving tear-free frames. wr_level may hold at WBUF_DEPTH for a whole active frame.
- Undefined: behaviour exactly as in Behaviour above.

Test Plan:
- Reset, then en=1, h_de=v_de=1 for 640 cycles from the first frame line -> mem_addr 0..639 on consecutive cycles starting at cycle 1, mem_we=0 throughout; pix_valid high for 640 cycles starting at cycle 3; pix_data equals the RAM model content.
- h_de=0 and v_de=1 (SCAN state), then 4 writes (addr 0x100..0x103, data 0xA0..0xA3) -> all accepted back-to-back with wr_ready=1; mem_we pulses at addr 0x100..0x103 in order; wr_level returns to 0.
- During an active line, push 5 writes -> first 4 accepted, wr_ready=0 on the fifth with wr_level=4 and no mem_we; at h_de fall, the fifth is accepted after the first drain cycle.
- Run a full 640x480 frame, then v_de=0 -> scan address returns to 0; the first read of the next frame is at addr 0; wrap at 307199 -> 0 is checked with v_de held high.
- Assert rst_n=0 for 1 cycle with wr_level=3 mid-line -> next cycle wr_level=0, mem_en=0, pix_valid=0; no stale write issued afterwards.
- With VGA_FB_ARB_VBLANK_WR_EN defined, write during horizontal blanking of an active frame -> no mem_we until v_de=0; then the writes drain on consecutive cycles.
